// File: rtl/system86_video_defs.sv
// Shared video capture definitions: FSM state codes
// and flag positions inside each buffered pixel word.
package system86_video_defs;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VS = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  // Word layout is {sof, sol, R, G, B}.
  localparam int FLAG_W  = 2;
  localparam int SOL_OFS = 0;
  localparam int SOF_OFS = 1;

  localparam int PIX_CNT_W = 20;

  typedef logic [PIX_CNT_W-1:0] pix_cnt_t;

  function automatic int flag_bit(
    input int color_w,
    input int ofs
  );
    return 3 * color_w + ofs;
  endfunction

endpackage

// File: rtl/video_capture_fifo.sv
// Pixel buffer with a registered head word; a word written
// into an empty buffer is shown to the consumer one cycle later.
module video_capture_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             CLK_6M,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic             fresh_q;
  logic             fresh_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign valid_o = ~empty_o & ~fresh_q;
  assign head_o  = head_q;

  assign pop_ok  = pop_i & valid_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rd_nxt  = rd_q + AW'(1);

  always_comb begin
    cnt_d   = cnt_q;
    head_d  = head_q;
    fresh_d = 1'b0;
    if (push_ok && !pop_ok)
      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop_ok && !push_ok)
      cnt_d = cnt_q - (AW+1)'(1);
    // A bypassed word must sit one cycle before it is visible.
    if (pop_ok) begin
      if (cnt_q != (AW+1)'(1)) begin
        head_d = mem_q[rd_nxt];
      end else if (push_ok) begin
        head_d  = wdata_i;
        fresh_d = 1'b1;
      end
    end else if (empty_o && push_ok) begin
      head_d  = wdata_i;
      fresh_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_6M) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      fresh_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_nxt;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      fresh_q <= fresh_d;
    end
  end

  always_ff @(posedge CLK_6M) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/video_frame_capture.sv
// Armed single-frame video grabber: waits for a VSYNC edge,
// buffers active pixels with frame/line flags until the next.
module video_frame_capture
  import system86_video_defs::*;
#(
  parameter int COLOR_W         = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                 CLK_6M,
  input  logic                 rst,
  input  logic                 HSYNC,
  input  logic                 VSYNC,
  input  logic                 HBLANK,
  input  logic                 VBLANK,
  input  logic [COLOR_W-1:0]   R,
  input  logic [COLOR_W-1:0]   G,
  input  logic [COLOR_W-1:0]   B,
  input  logic                 arm,
  input  logic                 px_ready,
  output logic                 px_valid,
  output logic [3*COLOR_W-1:0] px_data,
  output logic                 px_sof,
  output logic                 px_sol,
  output logic                 busy,
  output logic                 overflow,
  output logic                 frame_done,
  output logic [19:0]          pix_count
);

  localparam int PW    = 3 * COLOR_W;
  localparam int WW    = PW + FLAG_W;
  localparam int SOF_B = flag_bit(COLOR_W, SOF_OFS);
  localparam int SOL_B = flag_bit(COLOR_W, SOL_OFS);
  localparam pix_cnt_t CNT_MAX = '1;

  logic       vs_now;
  logic       vs_prev_q;
  logic       vs_start;
  logic       act;
  logic       act_prev_q;
  logic       sol;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       sof_pend_q;
  logic       sof_pend_d;
  logic       ovf_q;
  logic       ovf_d;
  pix_cnt_t   cnt_q;
  pix_cnt_t   cnt_d;
  logic       done_q;
  logic       done_d;

  logic          push;
  logic          pop;
  logic [WW-1:0] wdata;
  logic [WW-1:0] head;
  logic          fifo_valid;
  logic          fifo_full;
  logic          fifo_empty;

  logic unused_hsync;
  assign unused_hsync = HSYNC;

  assign vs_now   = (SYNC_ACTIVE_LOW != 0) ? ~VSYNC : VSYNC;
  assign vs_start = vs_now & ~vs_prev_q;
  assign act      = ~HBLANK & ~VBLANK;
  assign sol      = act & ~act_prev_q;
  assign pop      = fifo_valid & px_ready;

  always_comb begin
    wdata        = '0;
    wdata[PW-1:0] = {R, G, B};
    wdata[SOL_B] = sol;
    wdata[SOF_B] = sof_pend_q;
  end

  always_comb begin
    state_d    = state_q;
    sof_pend_d = sof_pend_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_WAIT_VS;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_WAIT_VS: begin
        if (vs_start) begin
          state_d    = ST_CAPTURE;
          sof_pend_d = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (vs_start) state_d = ST_DRAIN;
        else if (act) push = 1'b1;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pop in the same cycle frees the slot a full buffer needs.
    if (push) begin
      sof_pend_d = 1'b0;
      if (fifo_full && !pop)
        ovf_d = 1'b1;
      else if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + pix_cnt_t'(1);
    end
  end

  always_ff @(posedge CLK_6M) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sof_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      vs_prev_q  <= 1'b0;
      act_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sof_pend_q <= sof_pend_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      vs_prev_q  <= vs_now;
      act_prev_q <= act;
    end
  end

  video_capture_fifo #(
    .WIDTH(WW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK_6M  (CLK_6M),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .head_o  (head),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign px_valid   = fifo_valid;
  assign px_data    = head[PW-1:0];
  assign px_sof     = head[SOF_B];
  assign px_sol     = head[SOL_B];
  assign busy       = (state_q != ST_IDLE);
  assign overflow   = ovf_q;
  assign frame_done = done_q;
  assign pix_count  = cnt_q;

endmodule

// File: tb/tb_video_frame_capture.sv
// Randomized frame bench for video_frame_capture with a
// pixel scoreboard fed by a frame-level reference model.
module tb_video_frame_capture;

  localparam int CW = 8;
  localparam int PW = 3 * CW;

  logic          CLK_6M = 1'b0;
  logic          rst = 1'b0;
  logic          HSYNC = 1'b1;
  logic          VSYNC = 1'b1;
  logic          HBLANK = 1'b1;
  logic          VBLANK = 1'b1;
  logic [CW-1:0] R = '0;
  logic [CW-1:0] G = '0;
  logic [CW-1:0] B = '0;
  logic          arm = 1'b0;
  logic          px_ready = 1'b0;
  logic          px_valid;
  logic [PW-1:0] px_data;
  logic          px_sof;
  logic          px_sol;
  logic          busy;
  logic          overflow;
  logic          frame_done;
  logic [19:0]   pix_count;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int ready_mode = 1;

  // Expected pixels in emission order: {sof, sol, rgb}.
  logic [PW+1:0] exp_q[$];

  always #10 CLK_6M = ~CLK_6M;

  video_frame_capture dut (
    .CLK_6M     (CLK_6M),
    .rst        (rst),
    .HSYNC      (HSYNC),
    .VSYNC      (VSYNC),
    .HBLANK     (HBLANK),
    .VBLANK     (VBLANK),
    .R          (R),
    .G          (G),
    .B          (B),
    .arm        (arm),
    .px_ready   (px_ready),
    .px_valid   (px_valid),
    .px_data    (px_data),
    .px_sof     (px_sof),
    .px_sol     (px_sol),
    .busy       (busy),
    .overflow   (overflow),
    .frame_done (frame_done),
    .pix_count  (pix_count)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK_6M) begin
    if (frame_done) done_cnt++;
    if (px_valid && px_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pixel: got %0h expected none",
                 {px_sof, px_sol, px_data});
      end else begin
        chk("pixel", 32'({px_sof, px_sol, px_data}),
            32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic rdy();
    if (ready_mode == 0) return 1'b0;
    if (ready_mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(
    input logic          vs,
    input logic          hb,
    input logic          vb,
    input logic          a,
    input logic          r,
    input logic [PW-1:0] rgb
  );
    VSYNC    = ~vs;
    HSYNC    = ~hb;
    HBLANK   = hb;
    VBLANK   = vb;
    {R, G, B} = rgb;
    arm      = a;
    px_ready = r;
    @(posedge CLK_6M);
    #1;
  endtask

  task automatic blank(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b1, 1'b0, rdy(), '0);
  endtask

  task automatic vs_pulse();
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, rdy(), '0);
  endtask

  task automatic arm_pulse();
    step(1'b0, 1'b1, 1'b1, 1'b1, rdy(), '0);
  endtask

  task automatic pixel(input logic [PW-1:0] px);
    step(1'b0, 1'b0, 1'b0, 1'b0, rdy(), px);
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      blank(1);
      n++;
    end
    chk("frame_done_seen", 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic rand_frame(
    input int   w,
    input int   h,
    input int   junk,
    input logic rearm,
    input int   mode
  );
    int            d0;
    int            hb_n;
    logic          first;
    logic [PW-1:0] px;
    d0 = done_cnt;
    first = 1'b1;
    ready_mode = mode;
    arm_pulse();
    blank(2);
    for (int j = 0; j < junk; j++) pixel(PW'($urandom));
    blank(1);
    vs_pulse();
    blank(int'($urandom_range(1, 3)));
    for (int y = 0; y < h; y++) begin
      hb_n = int'($urandom_range(1, 3));
      repeat (hb_n) step(1'b0, 1'b1, 1'b0, 1'b0, rdy(), '0);
      for (int x = 0; x < w; x++) begin
        px = PW'($urandom);
        exp_q.push_back({first, 1'(x == 0), px});
        step(1'b0, 1'b0, 1'b0,
             1'(rearm && y == h - 1 && x == 0), rdy(), px);
        first = 1'b0;
      end
    end
    blank(2);
    vs_pulse();
    wait_done(d0);
    blank(3);
    chk("pix_count", 32'(pix_count), 32'(w * h));
    chk("overflow", 32'(overflow), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("sb_left", 32'(exp_q.size()), 32'd0);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int            d0;
    logic [PW-1:0] px;

    rst = 1'b0;
    arm = 1'b1;
    repeat (3) @(posedge CLK_6M);
    #1;
    chk("rst_valid", 32'(px_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_count", 32'(pix_count), 32'd0);
    chk("rst_data", 32'(px_data), 32'd0);
    chk("rst_sof", 32'(px_sof), 32'd0);
    chk("rst_sol", 32'(px_sol), 32'd0);
    rst = 1'b1;
    blank(2);
    chk("arm_in_reset", 32'(busy), 32'd0);

    // 4x3 window, consumer always ready
    rand_frame(4, 3, 0, 1'b0, 1);
    // Active pixels before the VSYNC edge are ignored
    rand_frame(3, 2, 5, 1'b0, 1);
    // Re-arm mid capture must be ignored
    rand_frame(4, 3, 0, 1'b1, 2);
    for (int f = 0; f < 6; f++)
      rand_frame(int'($urandom_range(1, 5)),
                 int'($urandom_range(1, 3)),
                 int'($urandom_range(0, 5)),
                 1'(f % 2), 2);

    // Overflow: 20 pixels into 16 slots with no consumer
    d0 = done_cnt;
    ready_mode = 0;
    arm_pulse();
    blank(1);
    vs_pulse();
    blank(1);
    for (int i = 0; i < 20; i++) begin
      px = PW'($urandom);
      if (i < 16) exp_q.push_back({1'(i == 0), 1'(i == 0), px});
      pixel(px);
      if (i == 0) chk("latency_n", 32'(px_valid), 32'd0);
      if (i == 1) chk("latency_n1", 32'(px_valid), 32'd1);
    end
    blank(2);
    vs_pulse();
    blank(2);
    chk("ovf_count", 32'(pix_count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd1);
    chk("ovf_valid", 32'(px_valid), 32'd1);
    ready_mode = 1;
    wait_done(d0);
    blank(3);
    chk("ovf_sb_left", 32'(exp_q.size()), 32'd0);
    chk("ovf_done", 32'(done_cnt - d0), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_idle", 32'(busy), 32'd0);

    // Full buffer: push and pop in the same cycle
    d0 = done_cnt;
    ready_mode = 0;
    arm_pulse();
    blank(1);
    vs_pulse();
    blank(1);
    for (int i = 0; i < 16; i++) begin
      px = PW'($urandom);
      exp_q.push_back({1'(i == 0), 1'(i == 0), px});
      pixel(px);
    end
    blank(2);
    chk("full_count", 32'(pix_count), 32'd16);
    chk("full_ovf", 32'(overflow), 32'd0);
    px = PW'($urandom);
    exp_q.push_back({1'b0, 1'b1, px});
    ready_mode = 1;
    pixel(px);
    ready_mode = 0;
    blank(2);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_count", 32'(pix_count), 32'd17);
    chk("fullpop_left", 32'(exp_q.size()), 32'd16);
    vs_pulse();
    ready_mode = 1;
    wait_done(d0);
    blank(3);
    chk("fullpop_sb_left", 32'(exp_q.size()), 32'd0);
    chk("fullpop_done", 32'(done_cnt - d0), 32'd1);

    // Reset in the middle of a capture
    d0 = done_cnt;
    ready_mode = 0;
    arm_pulse();
    blank(1);
    vs_pulse();
    blank(1);
    for (int i = 0; i < 7; i++) begin
      px = PW'($urandom);
      exp_q.push_back({1'(i == 0), 1'(i == 0), px});
      pixel(px);
    end
    blank(1);
    chk("pre_rst_count", 32'(pix_count), 32'd7);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("mid_rst_valid", 32'(px_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_count", 32'(pix_count), 32'd0);
    chk("mid_rst_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    ready_mode = 1;
    blank(6);
    chk("post_rst_done", 32'(done_cnt - d0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(px_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
